fp_add_sequencer: RTL and testbench

FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

---
 rtl/fp_add_sequencer_if.sv | 41 ++++
 rtl/fp_add_sequencer.sv | 127 ++++++++++++
 tb/tb_fp_add_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_sequencer_if.sv
// fp_add_sequencer_if
// Groups the three handshake paths around fp_add_sequencer: the caller
// request channel (in_*), the operand/result path to fp_addpipe (pipe_*)
// and the result delivery channel (out_*).
//   slave  : the sequencer's view. It receives requests and pipe results.
//            It drives in_ready, the pipe operands and the out_* channel.
//   master : the surroundings' view (caller, fp_addpipe and consumer),
//            with every direction reversed.
// WIDTH and TAG_W must match the parameters of the sequencer bound to it.
interface fp_add_sequencer_if #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic [WIDTH-1:0] pipe_a;
  logic [WIDTH-1:0] pipe_b;
  logic [3:0]       pipe_op;
  logic [WIDTH-1:0] pipe_result;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, pipe_result, out_ready,
    output in_ready, pipe_a, pipe_b, pipe_op, out_valid, out_result, out_tag, out_err
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, pipe_result, out_ready,
    input  in_ready, pipe_a, pipe_b, pipe_op, out_valid, out_result, out_tag, out_err
  );
endinterface

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer
// Issues tagged operations into a fixed-latency, non-resettable fp_addpipe.
// It tracks each operation alongside the pipe. It collects the results, in
// issue order, into a circular FIFO.
// A credit counter (in-flight ops plus FIFO entries) throttles issue, so the
// FIFO can never overflow.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fp_add_sequencer_if.slave, which carries
//         - the caller request channel (in_valid/in_ready/in_a/in_b/in_op/in_tag)
//         - the pipe path (pipe_a/pipe_b/pipe_op out, pipe_result in)
//         - the result channel (out_valid/out_ready/out_result/out_tag/out_err)
// Parameters: WIDTH, TAG_W, LATENCY (pipe latency), DEPTH (FIFO entries).
// DEPTH must be at least LATENCY+2.
module fp_add_sequencer #(
  parameter int WIDTH   = 24,
  parameter int TAG_W   = 5,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  fp_add_sequencer_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [TAG_W-1:0] tag;
  } track_t;

  // Stage i holds the op fired i edges ago. The last stage lines up with
  // pipe_result, one cycle before the FIFO write.
  track_t           track_q [LATENCY+1];
  track_t           tail;

  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [WIDTH-1:0] mem_result [DEPTH];
  logic [TAG_W-1:0] mem_tag    [DEPTH];
  logic             mem_err    [DEPTH];

  logic fire, push, pop, op_illegal;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // Explicit wrap so that non-power-of-two depths also behave as a ring.
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    case (bus.in_op)
      4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b1001: op_illegal = 1'b0;
      default:                                              op_illegal = 1'b1;
    endcase
  end

  // Gating with rst keeps the caller blocked for the whole reset window.
  // This holds even though occ_q is already cleared.
  assign bus.in_ready = ~rst & (occ_q < FULL_CNT);
  assign fire         = bus.in_valid & bus.in_ready;

  // The pipe sees a NOP code and zero operands on idle cycles.
  assign bus.pipe_a  = fire ? bus.in_a  : '0;
  assign bus.pipe_b  = fire ? bus.in_b  : '0;
  assign bus.pipe_op = fire ? bus.in_op : 4'b1111;

  assign tail = track_q[LATENCY];
  assign push = tail.valid;
  assign pop  = bus.out_valid & bus.out_ready;

  assign bus.out_valid  = (cnt_q != '0);
  assign bus.out_result = mem_result[rd_ptr_q];
  assign bus.out_tag    = mem_tag[rd_ptr_q];
  assign bus.out_err    = mem_err[rd_ptr_q];

  always_comb begin
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fire && !pop)      occ_d = occ_q + CNT_W'(1);
    else if (!fire && pop) occ_d = occ_q - CNT_W'(1);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // Clearing the tracker drops anything still inside fp_addpipe. The pipe
  // itself is not reset, and its stale results are never pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LATENCY; i++) track_q[i] <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      track_q[0] <= '{valid: fire, err: op_illegal, tag: bus.in_tag};
      for (int i = 1; i <= LATENCY; i++) track_q[i] <= track_q[i-1];
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // The storage has no reset. Entries are only visible once written, since
  // out_valid follows cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr_q] <= tail.err ? '0 : bus.pipe_result;
      mem_tag[wr_ptr_q]    <= tail.tag;
      mem_err[wr_ptr_q]    <= tail.err;
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer
// Directed test of fp_add_sequencer with a stand-in fp_addpipe model.
// The model has LATENCY+1 register stages, so a result issued at edge k is
// present after edge k+LATENCY.
// The stand-in computes integer arithmetic for each opcode:
//   0000 a+b, 0100 a-b, 0001 max, 0010 min, 1000 a, 1001 b, 1111 0
//   any other opcode returns ABCDEF
// The ABCDEF value makes the zeroing of illegal-op results visible.
module tb_fp_add_sequencer;
  localparam int WIDTH   = 24;
  localparam int TAG_W   = 5;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

  fp_add_sequencer #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .LATENCY(LATENCY), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [WIDTH-1:0] pipe_fn(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b0001: return (a > b) ? a : b;
      4'b0010: return (a < b) ? a : b;
      4'b1000: return a;
      4'b1001: return b;
      4'b1111: return '0;
      default: return 24'hABCDEF;
    endcase
  endfunction

  logic [WIDTH-1:0] model_q [LATENCY+1];
  always @(posedge clk) begin
    model_q[0] <= pipe_fn(bus.pipe_a, bus.pipe_b, bus.pipe_op);
    for (int i = 1; i <= LATENCY; i++) model_q[i] <= model_q[i-1];
  end
  assign bus.pipe_result = model_q[LATENCY];

  // Monitor: fires and pops are recorded mid-cycle, away from the edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int               fire_edge_q [$];
  logic [WIDTH-1:0] got_res_q   [$];
  logic [TAG_W-1:0] got_tag_q   [$];
  logic             got_err_q   [$];
  int               got_cyc_q   [$];

  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) fire_edge_q.push_back(cyc + 1);
    if (bus.out_valid && bus.out_ready) begin
      got_res_q.push_back(bus.out_result);
      got_tag_q.push_back(bus.out_tag);
      got_err_q.push_back(bus.out_err);
      got_cyc_q.push_back(cyc);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] tag_at(input int i);
    return (i < got_tag_q.size()) ? 32'(got_tag_q[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] res_at(input int i);
    return (i < got_res_q.size()) ? 32'(got_res_q[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] err_at(input int i);
    return (i < got_err_q.size()) ? 32'(got_err_q[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic int cyc_at(input int i);
    return (i < got_cyc_q.size()) ? got_cyc_q[i] : -1000;
  endfunction
  function automatic int fire_at(input int i);
    return (i < fire_edge_q.size()) ? fire_edge_q[i] : -1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    fire_edge_q.delete();
    got_res_q.delete();
    got_tag_q.delete();
    got_err_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic set_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [3:0] op, input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_tag   = tag;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_op    = 4'b0000;
    bus.in_tag   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int bad;
    int ready_drops;
    logic rdy;

    idle();
    bus.out_ready = 1'b0;

    // Reset state, with a request presented during reset.
    tick(); tick();
    set_op(24'h123456, 24'h000001, 4'b0000, 5'd1);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_pipe_op", bus.pipe_op, 4'hF);
    chk("rst_pipe_a", bus.pipe_a, 0);
    idle();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    clear();

    // Single add: latency, tag and result.
    bus.out_ready = 1'b1;
    tick();
    set_op(24'h3F8000, 24'h400000, 4'b0000, 5'd3);
    #1;
    chk("single_pipe_a", bus.pipe_a, 24'h3F8000);
    chk("single_pipe_b", bus.pipe_b, 24'h400000);
    chk("single_pipe_op", bus.pipe_op, 4'b0000);
    tick();
    idle();
    #1;
    chk("idle_pipe_op", bus.pipe_op, 4'hF);
    chk("idle_pipe_b", bus.pipe_b, 0);
    repeat (8) tick();
    chk("single_count", got_tag_q.size(), 1);
    chk("single_tag", tag_at(0), 3);
    chk("single_err", err_at(0), 0);
    chk("single_result", res_at(0), 24'h7F8000);
    chk("single_latency", cyc_at(0) - fire_at(0), 4);

    // Back-to-back: 20 fires, one per cycle.
    clear();
    ready_drops = 0;
    for (int i = 0; i < 20; i++) begin
      set_op(24'(i * 256), 24'(i + 1), 4'b0000, 5'(i));
      if (!bus.in_ready) ready_drops++;
      tick();
    end
    idle();
    repeat (10) tick();
    chk("b2b_ready_drops", ready_drops, 0);
    chk("b2b_fires", fire_edge_q.size(), 20);
    chk("b2b_count", got_tag_q.size(), 20);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("b2b_tag%0d", i), tag_at(i), i);
      chk($sformatf("b2b_res%0d", i), res_at(i), i * 256 + i + 1);
      if (cyc_at(i) != cyc_at(0) + i) bad++;
    end
    chk("b2b_spacing", bad, 0);
    chk("b2b_first_latency", cyc_at(0) - fire_at(0), 4);

    // Backpressure: exactly DEPTH accepted, then one more per pop.
    clear();
    bus.out_ready = 1'b0;
    t = 0;
    for (int i = 0; i < 14; i++) begin
      set_op(24'(t), 24'h000001, 4'b0000, 5'(t));
      rdy = bus.in_ready;
      tick();
      if (rdy) t++;
    end
    chk("bp_fires", fire_edge_q.size(), 8);
    chk("bp_ready_low", bus.in_ready, 0);
    chk("bp_no_pop", got_tag_q.size(), 0);
    chk("bp_head_tag_held", bus.out_tag, 0);
    chk("bp_head_res_held", bus.out_result, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_ready_after_pop", bus.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      set_op(24'(t), 24'h000001, 4'b0000, 5'(t));
      rdy = bus.in_ready;
      tick();
      if (rdy) t++;
    end
    chk("bp_fires_total", fire_edge_q.size(), 9);
    chk("bp_ready_low_again", bus.in_ready, 0);
    idle();
    bus.out_ready = 1'b1;
    repeat (14) tick();
    chk("bp_count", got_tag_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("bp_tag%0d", i), tag_at(i), i);
      chk($sformatf("bp_res%0d", i), res_at(i), i + 1);
    end

    // Illegal opcode between two legal ones.
    clear();
    set_op(24'd5, 24'd9, 4'b0001, 5'd8);  tick();
    set_op(24'd1, 24'd2, 4'b0111, 5'd9);  tick();
    set_op(24'd20, 24'd7, 4'b0100, 5'd10); tick();
    idle();
    repeat (8) tick();
    chk("ill_count", got_tag_q.size(), 3);
    chk("ill_tag0", tag_at(0), 8);
    chk("ill_res0", res_at(0), 9);
    chk("ill_err0", err_at(0), 0);
    chk("ill_tag1", tag_at(1), 9);
    chk("ill_res1", res_at(1), 0);
    chk("ill_err1", err_at(1), 1);
    chk("ill_tag2", tag_at(2), 10);
    chk("ill_res2", res_at(2), 13);
    chk("ill_err2", err_at(2), 0);

    // Reset with three ops in flight.
    clear();
    for (int i = 1; i <= 3; i++) begin
      set_op(24'(i), 24'(i), 4'b0000, 5'(i));
      tick();
    end
    idle();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_pipe_op", bus.pipe_op, 4'hF);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("mid_post_in_ready", bus.in_ready, 1);
    chk("mid_post_out_valid", bus.out_valid, 0);
    repeat (8) tick();
    chk("mid_no_stale", got_tag_q.size(), 0);
    set_op(24'h000100, 24'h000023, 4'b0000, 5'd4);
    tick();
    idle();
    repeat (8) tick();
    chk("mid_next_count", got_tag_q.size(), 1);
    chk("mid_next_tag", tag_at(0), 4);
    chk("mid_next_res", res_at(0), 24'h000123);

    // Simultaneous fire/pop, then simultaneous push/pop at DEPTH-1 entries.
    clear();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_op(24'(i * 3), 24'd2, 4'b0000, 5'(i));
      tick();
    end
    idle();
    repeat (6) tick();
    chk("sp_valid", bus.out_valid, 1);
    chk("sp_head0", bus.out_tag, 0);
    chk("sp_ready7", bus.in_ready, 1);
    set_op(24'd21, 24'd2, 4'b0000, 5'd7);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    set_op(24'd24, 24'd2, 4'b0000, 5'd8);
    chk("sp_ready_fire_pop", bus.in_ready, 1);
    tick();
    idle();
    chk("sp_ready_full", bus.in_ready, 0);
    tick(); tick(); tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("sp_ready_after", bus.in_ready, 1);
    chk("sp_valid_after", bus.out_valid, 1);
    chk("sp_head_after", bus.out_tag, 2);
    bus.out_ready = 1'b1;
    repeat (12) tick();
    chk("sp_count", got_tag_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("sp_tag%0d", i), tag_at(i), i);
      chk($sformatf("sp_res%0d", i), res_at(i), i * 3 + 2);
    end
    chk("sp_empty", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
